memory_bus_arbiter: RTL
=======================

// Module: memory_bus_arbiter
// PURPOSE
//  Shares the single memory_bus (memory system: RAM / frame buffer / IO) among
//  NUM_PORTS requesters, e.g. CPU, blitter and sprite DMA. Each requester sees the
//  same dispatch/busy/read_data protocol as a direct consumer. The arbiter queues
//  one request per port, grants round-robin, and runs one transaction at a time.
//  It routes read data back to the issuing port.
// PARAMETERS
//  NUM_PORTS   2   number of requesters (>=2); port 0 is first after reset
//  ADDR_WIDTH  32  address width, equal to memory_bus addr
//  DATA_WIDTH  8   data width, equal to memory_bus read/write data
// PORTS
//  clk_in            in   1                    system clock, single domain
//  rst_in            in   1                    synchronous, active-high reset
//  req_addr          in   NUM_PORTS*ADDR_WIDTH per-port address, port p at [p*AW +: AW]
//  req_write_data    in   NUM_PORTS*DATA_WIDTH per-port write data
//  req_dispatch_read in   NUM_PORTS            per-port 1-cycle read request pulse
//  req_dispatch_write in  NUM_PORTS            per-port 1-cycle write request pulse
//  req_read_data     out  NUM_PORTS*DATA_WIDTH per-port read result, held until next read completes
//  req_busy          out  NUM_PORTS            per-port: request pending or in flight
//  mem_addr          out  ADDR_WIDTH           to memory_bus.addr
//  mem_write_data    out  DATA_WIDTH           to memory_bus.write_data
//  mem_dispatch_read out  1                    to memory_bus.dispatch_read
//  mem_dispatch_write out 1                    to memory_bus.dispatch_write
//  mem_read_data     in   DATA_WIDTH           from memory_bus.read_data
//  mem_busy          in   1                    from memory_bus.busy
//  grant_id          out  $clog2(NUM_PORTS)    port owning the current or last transaction (debug)
// BEHAVIOUR
//  - All outputs are registered. Reset values: req_busy=0, req_read_data=0,
//    mem_dispatch_*=0, mem_addr=0, mem_write_data=0, grant_id=NUM_PORTS-1
//    (RR pointer, so port 0 wins first), FSM=IDLE, all pending slots cleared.
//  - Accept: in cycle t, when req_busy[p]=0 and a dispatch pulse is present, latch
//    addr, data and kind into slot p. req_busy[p]=1 from t+1. Read wins if both
//    pulses are set. Pulses while req_busy[p]=1 are ignored, with no queueing.
//  - FSM IDLE: if any slot is pending and mem_busy=0, grant the first pending port
//    after grant_id, modulo NUM_PORTS. Drive mem_addr/data and the matching
//    mem_dispatch_* = 1 for exactly one cycle. Go to ISSUE.
//  - ISSUE: dispatch deasserts and mem_addr/data are held. Go to WAIT.
//  - WAIT: while mem_busy=1, stay. On mem_busy=0, the transaction is done:
//    * for a read, req_read_data[grant] <= mem_read_data;
//    * clear the slot, req_busy[grant] <= 0, go to IDLE.
//    Other ports' req_read_data never change.
//  - Latency with the arbiter idle (port dispatch at cycle 0):
//    * mem dispatch appears at cycle 2;
//    * req_busy drops at mem-completion+1 (write: cycle 5; IO read: 5; RAM read: 6).
//  - The granted port may re-dispatch in the same cycle its req_busy is seen low.
//  - A port that keeps requesting cannot starve others: after port p is served,
//    p has the lowest priority.
//  - rst_in mid-transaction: return to reset state next cycle and drop the
//    in-flight transaction. The memory system shares rst_in.
//  - mem_busy=1 while in IDLE (not expected) blocks the grant; nothing is lost.
// TESTING
//  - Single write: port0 writes addr 0x1_0010, data 0xA5 at cycle 0
//    -> mem_dispatch_write at cycle 2 only; req_busy[0] high cycles 1-4.
//  - Single RAM read: port1 reads 0x1_0010 after the write above
//    -> req_read_data[1]=0xA5 and req_busy[1]=0 together at cycle 6; port0 data unchanged.
//  - Simultaneous: port0 and port1 dispatch reads in the same cycle after reset
//    -> port0 is served first, port1 next; exactly 2 mem dispatches.
//  - Fairness: both ports re-dispatch at every busy drop for 20 transactions
//    -> grants alternate 0,1,0,1...; no port waits for more than 1 other transaction.
//  - Ignored request: port0 pulses a write while req_busy[0]=1
//    -> no extra mem dispatch; memory contents unchanged at that address.
//  - Reset mid-read: assert rst_in in WAIT
//    -> next cycle all req_busy=0, dispatch=0; a new request after reset completes normally.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter that lets NUM_PORTS requesters share one memory_bus, one transaction at a time.
// Latency: mem dispatch 2 cycles after a port dispatch when idle; each port holds one request and ignores pulses while busy.
module memory_bus_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data,
  input  logic [NUM_PORTS-1:0]            req_dispatch_read,
  input  logic [NUM_PORTS-1:0]            req_dispatch_write,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] req_read_data,
  output logic [NUM_PORTS-1:0]            req_busy,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  output logic                            mem_dispatch_read,
  output logic                            mem_dispatch_write,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  input  logic                            mem_busy,
  output logic [GW-1:0]                   grant_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slot_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  slot_rd;
  logic [NUM_PORTS-1:0]  accept;
  logic                  arb_found;
  logic [GW-1:0]         arb_idx;
  logic                  xfer_done;

  // req_busy doubles as the slot-valid flag: a slot stays owned until its transaction completes.
  always_comb begin
    accept = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      accept[p] = !req_busy[p] && (req_dispatch_read[p] || req_dispatch_write[p]);
    end
  end

  // Search starts just after the last winner, so the last served port has lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!arb_found && req_busy[(int'(grant_id) + i) % NUM_PORTS]) begin
        arb_found = 1'b1;
        arb_idx   = GW'((int'(grant_id) + i) % NUM_PORTS);
      end
    end
  end

  assign xfer_done = (state == ST_WAIT) && !mem_busy;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_rd <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        slot_addr[p] <= '0;
        slot_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          slot_addr[p] <= req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data[p] <= req_write_data[p*DATA_WIDTH +: DATA_WIDTH];
          slot_rd[p]   <= req_dispatch_read[p];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      req_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          req_busy[p] <= 1'b1;
        end else if (xfer_done && (grant_id == GW'(p))) begin
          req_busy[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      grant_id           <= GW'(NUM_PORTS - 1);
      mem_addr           <= '0;
      mem_write_data     <= '0;
      mem_dispatch_read  <= 1'b0;
      mem_dispatch_write <= 1'b0;
    end else begin
      mem_dispatch_read  <= 1'b0;
      mem_dispatch_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_found && !mem_busy) begin
            grant_id       <= arb_idx;
            mem_addr       <= slot_addr[arb_idx];
            mem_write_data <= slot_data[arb_idx];
            if (slot_rd[arb_idx]) begin
              mem_dispatch_read <= 1'b1;
            end else begin
              mem_dispatch_write <= 1'b1;
            end
            state <= ST_ISSUE;
          end
        end
        // One-cycle gap gives the memory system time to raise busy.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!mem_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      req_read_data <= '0;
    end else if (xfer_done && slot_rd[grant_id]) begin
      req_read_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
    end
  end

endmodule
